runway_pattern_decoder: RTL and testbench

Receive-side counterpart of the runway light sequencer. Watches the 3-lamp pattern the sequencer drives one frame per `adv` strobe and recovers the wind mode that produced it: calm, right-to-left or left-to-right. It declares lock after `LOCK_N` consecutive consistent frame pairs and counts illegal lamp patterns. It sits on the observer/self-check side of the tug-of-war board, fed from the same frame strobe as the sequencer.

---
 rtl/runway_pkg.sv | 32 +++
 rtl/runway_pair_classifier.sv | 29 ++
 rtl/runway_pattern_decoder.sv | 139 +++++++++++++
 tb/tb_runway_pattern_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/runway_pkg.sv
// Shared types and constants for the runway lamp pattern decoder.
//   mode_t      : wind mode; MODE_NONE marks a pair that fits no mode
//   LAMP_*      : the four legal lamp patterns (bit2 = left lamp)
//   dec_state_t : decoder FSM state
//   is_legal()  : true for the four legal lamp patterns
package runway_pkg;

   typedef enum logic [1:0] {
      MODE_CALM = 2'b00,
      MODE_RTOL = 2'b01,
      MODE_LTOR = 2'b10,
      MODE_NONE = 2'b11
   } mode_t;

   localparam logic [2:0] LAMP_L  = 3'b100;
   localparam logic [2:0] LAMP_M  = 3'b010;
   localparam logic [2:0] LAMP_R  = 3'b001;
   localparam logic [2:0] LAMP_LR = 3'b101;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      HUNT   = 2'b01,
      TRACK  = 2'b10,
      LOCKED = 2'b11
   } dec_state_t;

   function automatic logic is_legal(input logic [2:0] lamps);
      return (lamps == LAMP_L) || (lamps == LAMP_M) ||
             (lamps == LAMP_R) || (lamps == LAMP_LR);
   endfunction

endpackage

// File: rtl/runway_pair_classifier.sv
// Combinational classifier for a pair of consecutive lamp frames.
// Ports:
//   prev : previous frame pattern
//   cur  : current frame pattern
//   cls  : mode the pair belongs to, MODE_NONE when the pair fits no mode
module runway_pair_classifier
   import runway_pkg::*;
(
   input  logic [2:0] prev,
   input  logic [2:0] cur,
   output mode_t      cls
);

   always_comb begin
      cls = MODE_NONE;
      case ({prev, cur})
         {LAMP_M,  LAMP_LR},
         {LAMP_LR, LAMP_M}:  cls = MODE_CALM;
         {LAMP_R,  LAMP_M},
         {LAMP_M,  LAMP_L},
         {LAMP_L,  LAMP_R}:  cls = MODE_RTOL;
         {LAMP_L,  LAMP_M},
         {LAMP_M,  LAMP_R},
         {LAMP_R,  LAMP_L}:  cls = MODE_LTOR;
         default:            cls = MODE_NONE;
      endcase
   end

endmodule

// File: rtl/runway_pattern_decoder.sv
// Recovers the wind mode from the lamp pattern driven by the runway light
// sequencer, declaring lock after LOCK_N consecutive same-class frame pairs
// and counting illegal frames.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   adv         : frame strobe; lights is sampled only when adv=1
//   lights      : lamp pattern, bit2 = left lamp
//   mode        : last locked mode (00 calm, 01 right-to-left, 10 left-to-right)
//   mode_valid  : set once any lock has occurred since reset
//   locked      : current mode confirmed
//   glitch      : one-cycle pulse after an illegal frame
//   err_count   : saturating glitch count
//   dbg_state   : current FSM state (dec_state_t encoding)
// Handshake: adv is a bare strobe with no back-pressure; every clock edge
// with adv=1 consumes exactly one frame, including back-to-back cycles.
module runway_pattern_decoder
   import runway_pkg::*;
#(
   parameter int LOCK_N = 3,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             adv,
   input  logic [2:0]       lights,
   output logic [1:0]       mode,
   output logic             mode_valid,
   output logic             locked,
   output logic             glitch,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       dbg_state
);

   localparam logic [3:0] LOCK_N4 = 4'(LOCK_N);

   dec_state_t state;
   logic [2:0] prev;
   mode_t      cand;
   mode_t      mode_r;
   logic [3:0] cnt;
   mode_t      cls;

   runway_pair_classifier u_cls (
      .prev (prev),
      .cur  (lights),
      .cls  (cls)
   );

   assign mode      = mode_r;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         prev       <= 3'b000;
         cand       <= MODE_NONE;
         cnt        <= 4'd0;
         mode_r     <= MODE_CALM;
         mode_valid <= 1'b0;
         locked     <= 1'b0;
         glitch     <= 1'b0;
         err_count  <= '0;
      end else begin
         glitch <= 1'b0;
         if (adv) begin
            if (!is_legal(lights)) begin
               // Illegal frame: drop the pair history and start over.
               glitch <= 1'b1;
               if (err_count != '1) err_count <= err_count + ERR_W'(1);
               state  <= EMPTY;
               locked <= 1'b0;
               cand   <= MODE_NONE;
               cnt    <= 4'd0;
            end else begin
               prev <= lights;
               case (state)
                  EMPTY: state <= HUNT;
                  HUNT: begin
                     if (cls != MODE_NONE) begin
                        cand <= cls;
                        cnt  <= 4'd1;
                        if (LOCK_N == 1) begin
                           state      <= LOCKED;
                           mode_r     <= cls;
                           mode_valid <= 1'b1;
                           locked     <= 1'b1;
                        end else begin
                           state <= TRACK;
                        end
                     end
                  end
                  TRACK: begin
                     if (cls == MODE_NONE) begin
                        state <= HUNT;
                        cnt   <= 4'd0;
                     end else if (cls == cand) begin
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == LOCK_N4) begin
                           state      <= LOCKED;
                           mode_r     <= cand;
                           mode_valid <= 1'b1;
                           locked     <= 1'b1;
                        end
                     end else begin
                        cand <= cls;
                        cnt  <= 4'd1;
                        // With LOCK_N=1 a single pair of the new class is enough.
                        if (LOCK_N == 1) begin
                           state      <= LOCKED;
                           mode_r     <= cls;
                           mode_valid <= 1'b1;
                           locked     <= 1'b1;
                        end
                     end
                  end
                  LOCKED: begin
                     if (cls == MODE_NONE) begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        cnt    <= 4'd0;
                     end else if (cls != mode_r) begin
                        cand <= cls;
                        cnt  <= 4'd1;
                        if (LOCK_N == 1) begin
                           mode_r <= cls;
                        end else begin
                           state  <= TRACK;
                           locked <= 1'b0;
                        end
                     end
                  end
                  default: state <= EMPTY;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_runway_pattern_decoder.sv
// Directed bench for runway_pattern_decoder: a LOCK_N=3/ERR_W=8 instance
// carries the main scenarios, an ERR_W=2 instance on the same inputs shows
// counter saturation. Inputs change on the falling edge, outputs are
// checked on the following falling edge.
module tb_runway_pattern_decoder;
   import runway_pkg::*;

   logic       clk;
   logic       reset;
   logic       adv;
   logic [2:0] lights;

   logic [1:0] mode;
   logic       mode_valid;
   logic       locked;
   logic       glitch;
   logic [7:0] err_count;
   logic [1:0] dbg_state;

   logic [1:0] mode2;
   logic       mode_valid2;
   logic       locked2;
   logic       glitch2;
   logic [1:0] err_count2;
   logic [1:0] dbg_state2;

   int checks;
   int errors;

   runway_pattern_decoder #(.LOCK_N(3), .ERR_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .adv        (adv),
      .lights     (lights),
      .mode       (mode),
      .mode_valid (mode_valid),
      .locked     (locked),
      .glitch     (glitch),
      .err_count  (err_count),
      .dbg_state  (dbg_state)
   );

   runway_pattern_decoder #(.LOCK_N(3), .ERR_W(2)) dut_sat (
      .clk        (clk),
      .reset      (reset),
      .adv        (adv),
      .lights     (lights),
      .mode       (mode2),
      .mode_valid (mode_valid2),
      .locked     (locked2),
      .glitch     (glitch2),
      .err_count  (err_count2),
      .dbg_state  (dbg_state2)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one frame for one edge; adv stays high (for back-to-back use).
   task automatic frame_hold(input logic [2:0] l);
      adv    = 1'b1;
      lights = l;
      @(negedge clk);
   endtask

   // One isolated frame.
   task automatic send(input logic [2:0] l);
      frame_hold(l);
      adv = 1'b0;
   endtask

   task automatic idle(input int n);
      adv = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Reset with an illegal frame strobed at the same time: reset must win.
   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      adv    = 1'b1;
      lights = 3'b111;
      @(negedge clk);
      reset  = 1'b0;
      adv    = 1'b0;
      lights = 3'b000;
   endtask

   task automatic check_all(input string tag, input logic [1:0] m, input logic mv,
                            input logic lk, input logic g, input logic [7:0] e);
      check({tag, ".mode"},       32'(mode),       32'(m));
      check({tag, ".mode_valid"}, 32'(mode_valid), 32'(mv));
      check({tag, ".locked"},     32'(locked),     32'(lk));
      check({tag, ".glitch"},     32'(glitch),     32'(g));
      check({tag, ".err_count"},  32'(err_count),  32'(e));
   endtask

   logic [2:0] bad_pat [4];

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      adv    = 1'b0;
      lights = 3'b000;
      bad_pat[0] = 3'b000;
      bad_pat[1] = 3'b011;
      bad_pat[2] = 3'b110;
      bad_pat[3] = 3'b111;

      // reset state
      do_reset();
      check_all("rst", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
      check("rst.state", 32'(dbg_state), 32'(EMPTY));

      // calm lock
      send(3'b010);
      check("calm1.state", 32'(dbg_state), 32'(HUNT));
      send(3'b101);
      check("calm2.state", 32'(dbg_state), 32'(TRACK));
      send(3'b010);
      check("calm3.locked", 32'(locked), 32'd0);
      send(3'b101);
      check_all("calm4", 2'b00, 1'b1, 1'b1, 1'b0, 8'd0);

      // glitch out of calm lock
      send(3'b111);
      check_all("glitch", 2'b00, 1'b1, 1'b0, 1'b1, 8'd1);
      check("glitch.state", 32'(dbg_state), 32'(EMPTY));
      idle(1);
      check("glitch.pulse_end", 32'(glitch), 32'd0);
      send(3'b010);
      check("glitch.next_state", 32'(dbg_state), 32'(HUNT));
      check("glitch.next_locked", 32'(locked), 32'd0);

      // adv=0 gating with illegal patterns on the lamps
      for (int i = 0; i < 10; i++) begin
         adv    = 1'b0;
         lights = bad_pat[i % 4];
         @(negedge clk);
         check("gate.glitch", 32'(glitch), 32'd0);
         check("gate.err", 32'(err_count), 32'd1);
         check("gate.state", 32'(dbg_state), 32'(HUNT));
      end
      check_all("gate.end", 2'b00, 1'b1, 1'b0, 1'b0, 8'd1);
      // previous frame 010 was kept through the gap: 010->101 is calm
      send(3'b101);
      check("gate.resume", 32'(dbg_state), 32'(TRACK));

      // right-to-left lock then switch to left-to-right
      do_reset();
      send(3'b001);
      send(3'b010);
      send(3'b100);
      check("rtol3.locked", 32'(locked), 32'd0);
      send(3'b001);
      check_all("rtol4", 2'b01, 1'b1, 1'b1, 1'b0, 8'd0);
      send(3'b100);
      check("sw1.locked", 32'(locked), 32'd0);
      check("sw1.mode", 32'(mode), 32'd1);
      check("sw1.state", 32'(dbg_state), 32'(TRACK));
      send(3'b010);
      check("sw2.locked", 32'(locked), 32'd0);
      check("sw2.mode", 32'(mode), 32'd1);
      send(3'b001);
      check("sw3.locked", 32'(locked), 32'd1);
      check("sw3.mode", 32'(mode), 32'd2);
      send(3'b100);
      check("sw4.locked", 32'(locked), 32'd1);
      send(3'b010);
      check_all("sw5", 2'b10, 1'b1, 1'b1, 1'b0, 8'd0);
      // repeat pattern is unlisted: back to HUNT, mode held
      send(3'b010);
      check("rep.state", 32'(dbg_state), 32'(HUNT));
      check_all("rep", 2'b10, 1'b1, 1'b0, 1'b0, 8'd0);

      // saturation: ERR_W=2 instance reads 1,2,3,3,3
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(bad_pat[i % 4]);
         check("sat.err2", 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'd3);
         check("sat.err8", 32'(err_count), 32'(i + 1));
         check("sat.glitch2", 32'(glitch2), 32'd1);
      end

      // reset in the middle of TRACK
      do_reset();
      send(3'b100);
      send(3'b010);
      check("mid.state", 32'(dbg_state), 32'(TRACK));
      do_reset();
      check_all("mid.rst", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0);
      check("mid.rst_state", 32'(dbg_state), 32'(EMPTY));

      // back-to-back frames relock calm
      frame_hold(3'b010);
      frame_hold(3'b101);
      frame_hold(3'b010);
      check("b2b3.locked", 32'(locked), 32'd0);
      frame_hold(3'b101);
      adv = 1'b0;
      check_all("b2b4", 2'b00, 1'b1, 1'b1, 1'b0, 8'd0);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
